// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: RegDst encodings,
// the $zero register address, the default data width and the grant type.
package rf_write_arbiter_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned REG_ADDR_W     = 5;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_SWI = 2'b10;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Which requester owns the write port this cycle
  typedef enum logic [1:0] {
    GntIdle,
    GntPipe,
    GntAux
  } grant_e;

  // Pipeline destination select; the unused encoding 2'b11 falls back to rd
  function automatic logic [REG_ADDR_W-1:0] resolve_waddr(
    input logic [1:0]            regdst,
    input logic [REG_ADDR_W-1:0] rt,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] swi
  );
    logic [REG_ADDR_W-1:0] addr;
    case (regdst)
      REGDST_RT:  addr = rt;
      REGDST_SWI: addr = swi;
      default:    addr = rd;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/rf_aux_fifo.sv
// Small synchronous FIFO holding aux-unit results (address + data) until the
// arbiter grants them the register-file write port.
module rf_aux_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Overflow/underflow requests are dropped so the pointers stay consistent
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. queued aux results,
// with a starvation guard that stalls the pipeline for one pop when the aux
// head has waited too long. Registered write outputs, one cycle after grant.
// Optional statistics counters are enabled with `define RF_WRITE_ARB_STATS_EN.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned AUX_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DATA_W       = DATA_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pipe_wb_valid_i,
  input  logic [1:0]        pipe_regdst_i,
  input  logic [4:0]        pipe_rt_i,
  input  logic [4:0]        pipe_rd_i,
  input  logic [4:0]        swi_reg_i,
  input  logic [DATA_W-1:0] pipe_wdata_i,
  output logic              pipe_stall_o,
  input  logic              aux_valid_i,
  output logic              aux_ready_o,
  input  logic [4:0]        aux_waddr_i,
  input  logic [DATA_W-1:0] aux_wdata_i,
  output logic              rf_we_o,
  output logic [4:0]        rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              aux_pending_o
`ifdef RF_WRITE_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt_o,
  output logic [15:0]       starve_cnt_o
`endif
);

  localparam int unsigned EntryW  = REG_ADDR_W + DATA_W;
  localparam int unsigned CntW    = $clog2(AUX_DEPTH + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveLast = StarveW'(STARVE_LIMIT - 1);

  grant_e             grant;
  logic               fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [CntW-1:0]    fifo_count;
  logic [EntryW-1:0]  fifo_head;
  logic [4:0]         head_waddr;
  logic [DATA_W-1:0]  head_wdata;

  logic               starve_flag_q, starve_flag_d;
  logic [StarveW-1:0] wait_cnt_q, wait_cnt_d;

  logic               rf_we_q, rf_we_d;
  logic [4:0]         rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

  assign fifo_push = aux_valid_i && aux_ready_o;
  assign fifo_pop  = (grant == GntAux);

  assign {head_waddr, head_wdata} = fifo_head;

  rf_aux_fifo #(
    .DEPTH (AUX_DEPTH),
    .WIDTH (EntryW)
  ) u_aux_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({aux_waddr_i, aux_wdata_i}),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Ready comes from the registered count only, so a same-cycle pop never frees a slot
  assign aux_ready_o   = !fifo_full;
  assign aux_pending_o = (fifo_count != '0);
  assign pipe_stall_o  = starve_flag_q;

  // Grant priority: starved aux head, then pipeline, then any queued aux result
  always_comb begin
    grant = GntIdle;
    if (starve_flag_q) begin
      grant = GntAux;
    end else if (pipe_wb_valid_i) begin
      grant = GntPipe;
    end else if (!fifo_empty) begin
      grant = GntAux;
    end
  end

  // Starvation tracking: count cycles the head waits without being popped
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    starve_flag_d = starve_flag_q;
    if (fifo_pop || fifo_empty) begin
      wait_cnt_d = '0;
    end else begin
      wait_cnt_d = wait_cnt_q + StarveW'(1);
    end
    if (fifo_pop) begin
      starve_flag_d = 1'b0;
    end else if (!fifo_empty && (wait_cnt_q == StarveLast)) begin
      starve_flag_d = 1'b1;
    end
  end

  // Starvation state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q    <= '0;
      starve_flag_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      starve_flag_q <= starve_flag_d;
    end
  end

  // Write-port next-state; a granted write to $zero is consumed but not enabled
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    unique case (grant)
      GntPipe: begin
        rf_waddr_d = resolve_waddr(pipe_regdst_i, pipe_rt_i, pipe_rd_i, swi_reg_i);
        rf_wdata_d = pipe_wdata_i;
        rf_we_d    = (rf_waddr_d != REG_ZERO);
      end
      GntAux: begin
        rf_waddr_d = head_waddr;
        rf_wdata_d = head_wdata;
        rf_we_d    = (rf_waddr_d != REG_ZERO);
      end
      default: ;
    endcase
  end

  // Registered write port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

`ifdef RF_WRITE_ARB_STATS_EN
  logic [15:0] conflict_cnt_q;
  logic [15:0] starve_cnt_q;

  // Saturating event counters: pipeline/queue contention and stall cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
      starve_cnt_q   <= '0;
    end else begin
      if (pipe_wb_valid_i && !fifo_empty && (conflict_cnt_q != 16'hFFFF)) begin
        conflict_cnt_q <= conflict_cnt_q + 16'd1;
      end
      if (starve_flag_q && (starve_cnt_q != 16'hFFFF)) begin
        starve_cnt_q <= starve_cnt_q + 16'd1;
      end
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
  assign starve_cnt_o   = starve_cnt_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the arbitration rules.
module tb_rf_write_arbiter;

  localparam int unsigned AUX_DEPTH    = 2;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned DATA_W       = 32;

  logic              clk;
  logic              rst_n;
  logic              pipe_wb_valid;
  logic [1:0]        pipe_regdst;
  logic [4:0]        pipe_rt;
  logic [4:0]        pipe_rd;
  logic [4:0]        swi_reg;
  logic [DATA_W-1:0] pipe_wdata;
  logic              pipe_stall;
  logic              aux_valid;
  logic              aux_ready;
  logic [4:0]        aux_waddr;
  logic [DATA_W-1:0] aux_wdata;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              aux_pending;

  rf_write_arbiter #(
    .AUX_DEPTH    (AUX_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT),
    .DATA_W       (DATA_W)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .pipe_wb_valid_i (pipe_wb_valid),
    .pipe_regdst_i   (pipe_regdst),
    .pipe_rt_i       (pipe_rt),
    .pipe_rd_i       (pipe_rd),
    .swi_reg_i       (swi_reg),
    .pipe_wdata_i    (pipe_wdata),
    .pipe_stall_o    (pipe_stall),
    .aux_valid_i     (aux_valid),
    .aux_ready_o     (aux_ready),
    .aux_waddr_i     (aux_waddr),
    .aux_wdata_i     (aux_wdata),
    .rf_we_o         (rf_we),
    .rf_waddr_o      (rf_waddr),
    .rf_wdata_o      (rf_wdata),
    .aux_pending_o   (aux_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [36:0]       aux_q [$];
  int                head_wait = 0;
  logic              exp_we = 1'b0;
  logic [4:0]        exp_addr = '0;
  logic [DATA_W-1:0] exp_data = '0;
  bit                last_stall = 1'b0;
  bit                last_acc = 1'b0;
  int                stall_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] dest_of(input logic [1:0] sel, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] swi);
    if (sel == 2'b00) return rt;
    if (sel == 2'b10) return swi;
    return rd;
  endfunction

  task automatic model_reset();
    aux_q.delete();
    head_wait  = 0;
    exp_we     = 1'b0;
    exp_addr   = '0;
    exp_data   = '0;
    last_stall = 1'b0;
    last_acc   = 1'b0;
  endtask

  // One clock: check the pre-edge outputs, advance the model, check the write port
  task automatic cycle();
    bit          stall, rdy, gnt, popped, had_entry;
    logic [4:0]  a;
    logic [31:0] d;
    @(negedge clk);
    stall     = (head_wait >= STARVE_LIMIT);
    rdy       = (aux_q.size() < AUX_DEPTH);
    had_entry = (aux_q.size() != 0);
    chk("pipe_stall", pipe_stall, stall);
    chk("aux_ready", aux_ready, rdy);
    chk("aux_pending", aux_pending, had_entry);
    gnt    = 1'b0;
    popped = 1'b0;
    a      = '0;
    d      = '0;
    if (stall || (!pipe_wb_valid && had_entry)) begin
      {a, d} = aux_q.pop_front();
      gnt    = 1'b1;
      popped = 1'b1;
    end else if (pipe_wb_valid) begin
      a   = dest_of(pipe_regdst, pipe_rt, pipe_rd, swi_reg);
      d   = pipe_wdata;
      gnt = 1'b1;
    end
    if (aux_valid && rdy) aux_q.push_back({aux_waddr, aux_wdata});
    if (popped || !had_entry) head_wait = 0;
    else head_wait++;
    if (gnt) begin
      exp_addr = a;
      exp_data = d;
    end
    exp_we     = gnt && (a != 5'd0);
    last_stall = stall;
    last_acc   = aux_valid && rdy;
    if (stall) stall_seen++;
    @(posedge clk);
    #1;
    chk("rf_we", rf_we, exp_we);
    if (exp_we) begin
      chk("rf_waddr", rf_waddr, exp_addr);
      chk("rf_wdata", rf_wdata, exp_data);
    end
  endtask

  task automatic pipe_req(input logic v, input logic [1:0] sel, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] data);
    pipe_wb_valid = v;
    pipe_regdst   = sel;
    pipe_rt       = rt;
    pipe_rd       = rd;
    pipe_wdata    = data;
  endtask

  task automatic aux_req(input logic v, input logic [4:0] addr, input logic [31:0] data);
    aux_valid = v;
    aux_waddr = addr;
    aux_wdata = data;
  endtask

  initial begin
    bit saw_aux;
    rst_n = 1'b0;
    swi_reg = 5'd31;
    pipe_req(1'b0, 2'b00, 5'd0, 5'd0, 32'h0);
    aux_req(1'b0, 5'd0, 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rf_we", rf_we, 1'b0);
    chk("reset_rf_waddr", rf_waddr, 5'd0);
    chk("reset_rf_wdata", rf_wdata, 32'h0);
    chk("reset_stall", pipe_stall, 1'b0);
    chk("reset_pending", aux_pending, 1'b0);
    #2 rst_n = 1'b1;
    #1 chk("reset_ready", aux_ready, 1'b1);

    // Test 1: R-type writeback
    pipe_req(1'b1, 2'b01, 5'd4, 5'd9, 32'hA5A5_0001);
    cycle();
    chk("t1_we", rf_we, 1'b1);
    chk("t1_waddr", rf_waddr, 5'd9);
    chk("t1_wdata", rf_wdata, 32'hA5A5_0001);

    // Test 2: rt, swi_reg, and the 2'b11 fallback to rd
    pipe_req(1'b1, 2'b00, 5'd3, 5'd20, 32'h0000_0002);
    cycle();
    chk("t2_rt", rf_waddr, 5'd3);
    pipe_req(1'b1, 2'b10, 5'd3, 5'd20, 32'h0000_0003);
    cycle();
    chk("t2_swi", rf_waddr, 5'd31);
    pipe_req(1'b1, 2'b11, 5'd3, 5'd7, 32'h0000_0004);
    cycle();
    chk("t2_rd11", rf_waddr, 5'd7);
    chk("t2_we", rf_we, 1'b1);

    // Test 3: lone aux result drains while the pipe is idle
    pipe_req(1'b0, 2'b00, 5'd0, 5'd0, 32'h0);
    aux_req(1'b1, 5'd12, 32'h0000_1234);
    cycle();
    aux_req(1'b0, 5'd0, 32'h0);
    cycle();
    chk("t3_we", rf_we, 1'b1);
    chk("t3_waddr", rf_waddr, 5'd12);
    chk("t3_wdata", rf_wdata, 32'h0000_1234);
    chk("t3_pending", aux_pending, 1'b0);

    // Test 4: starvation guard under continuous pipeline writebacks
    stall_seen = 0;
    saw_aux    = 1'b0;
    aux_req(1'b1, 5'd17, 32'hDEAD_0017);
    for (int i = 0; i < 9; i++) begin
      if (!last_stall) pipe_req(1'b1, 2'b01, 5'd0, 5'(i + 1), 32'h4000_0000 + i);
      cycle();
      aux_req(1'b0, 5'd0, 32'h0);
      if (rf_we && rf_waddr == 5'd17) saw_aux = 1'b1;
    end
    chk("t4_stall_cycles", stall_seen, 1);
    chk("t4_aux_written", saw_aux, 1'b1);

    // Test 5: fill the queue while the pipe is busy, then drain in order
    pipe_req(1'b1, 2'b01, 5'd0, 5'd2, 32'h5000_0000);
    aux_req(1'b1, 5'd21, 32'h0000_0021);
    cycle();
    aux_req(1'b1, 5'd22, 32'h0000_0022);
    cycle();
    chk("t5_ready_full", aux_ready, 1'b0);
    aux_req(1'b1, 5'd23, 32'h0000_0023);
    cycle();
    aux_req(1'b0, 5'd0, 32'h0);
    pipe_req(1'b0, 2'b00, 5'd0, 5'd0, 32'h0);
    cycle();
    chk("t5_first", rf_waddr, 5'd21);
    cycle();
    chk("t5_second", rf_waddr, 5'd22);
    cycle();
    chk("t5_no_third", rf_we, 1'b0);

    // Test 6: $zero write is suppressed; reset discards queued results
    pipe_req(1'b1, 2'b01, 5'd5, 5'd0, 32'h6000_0000);
    cycle();
    chk("t6_zero_we", rf_we, 1'b0);
    pipe_req(1'b1, 2'b01, 5'd0, 5'd8, 32'h6000_0001);
    aux_req(1'b1, 5'd24, 32'h0000_0024);
    cycle();
    aux_req(1'b1, 5'd25, 32'h0000_0025);
    cycle();
    aux_req(1'b0, 5'd0, 32'h0);
    pipe_req(1'b0, 2'b00, 5'd0, 5'd0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pending", aux_pending, 1'b0);
    chk("t6_rst_we", rf_we, 1'b0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Random traffic; stalled or refused requests are held until taken
    for (int i = 0; i < 500; i++) begin
      if (!(last_stall && pipe_wb_valid)) begin
        pipe_wb_valid = ($urandom_range(99) < 70);
        pipe_regdst   = 2'($urandom_range(3));
        pipe_rt       = 5'($urandom);
        pipe_rd       = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
        swi_reg       = 5'($urandom);
        pipe_wdata    = $urandom;
      end
      if (!(aux_valid && !last_acc)) begin
        aux_valid = ($urandom_range(99) < 35);
        aux_waddr = 5'($urandom);
        aux_wdata = $urandom;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Owns the single register-file write port. Arbitrates between the in-order pipeline writeback and a multi-cycle auxiliary unit (mul/div, swi completion), which returns results through a small queue. Resolves the destination register from the RegDst encoding and drives registered write signals into the register file. A starvation guard prevents the aux queue from stalling indefinitely behind continuous pipeline writebacks.

Parameters:
AUX_DEPTH, 2, aux result queue entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive cycles an aux head may wait before the pipeline is stalled
DATA_W, 32, write data width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pipe_wb_valid  in  1  pipeline writeback request this cycle
pipe_regdst  in  2  00 rt (I-type), 01 rd (R-type), 10 swi_reg (custom), 11 treated as rd
pipe_rt  in  5  rt field
pipe_rd  in  5  rd field
swi_reg  in  5  swi destination register
pipe_wdata  in  DATA_W  pipeline result
pipe_stall  out  1  pipeline must hold WB inputs stable; arbiter ignores pipe_wb_valid
aux_valid  in  1  aux result offered
aux_ready  out  1  queue can accept (count < AUX_DEPTH)
aux_waddr  in  5  aux destination register
aux_wdata  in  DATA_W  aux result
rf_we  out  1  register-file write enable
rf_waddr  out  5  write address
rf_wdata  out  DATA_W  write data
aux_pending  out  1  queue non-empty

Behaviour:
- Reset, async on rst_n low: rf_we=0, rf_waddr=0, rf_wdata=0, queue emptied (count=0, pointers 0), starve counter 0, pipe_stall=0, aux_ready=1 once reset is released. Reset mid-operation discards all queued results.
- Push: aux_valid && aux_ready writes an entry at the tail. aux_ready derives from the registered count only. When full, aux_ready=0 even if a pop occurs in the same cycle.
- Grant, evaluated every cycle, priority order:
  1) starve_flag=1: pop head.
  2) pipe_wb_valid=1: pipeline write.
  3) queue non-empty: pop head.
  4) Otherwise idle.
- Address resolution (pipeline): 00->pipe_rt, 01->pipe_rd, 10->swi_reg, 11->pipe_rd.
- Output stage: registered, 1-cycle latency. rf_we/rf_waddr/rf_wdata update on the edge after the grant. rf_we=0 in idle cycles; rf_waddr/rf_wdata hold their last values.
- $zero: a granted write with address 0 still consumes the grant (pop or pipeline accept), but rf_we=0.
- Starvation counter:
  - Increments each cycle the queue is non-empty and no pop occurs.
  - Clears on any pop or when the queue is empty.
  - starve_flag is registered: set when the counter reaches STARVE_LIMIT-1 and increments; cleared on the cycle a pop occurs.
  - pipe_stall = starve_flag (combinational from the register).
- Simultaneous push into an empty queue while the pipeline writes: entry is queued, and the counter starts next cycle.
- Push and pop in the same cycle with count between 0 and AUX_DEPTH: count unchanged. Pointers wrap modulo AUX_DEPTH.
- aux_pending = (count != 0).

Optional Feature:
RF_WRITE_ARB_STATS_EN
- Defined: adds outputs conflict_cnt[15:0] and starve_cnt[15:0], both reset to 0.
  - conflict_cnt increments each cycle pipe_wb_valid && queue non-empty.
  - starve_cnt increments each cycle pipe_stall=1.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package: RegDst encoding constants (REGDST_RT=2'b00, REGDST_RD=2'b01, REGDST_SWI=2'b10), REG_ZERO=5'd0, DATA_W default.
- One sub-module: rf_aux_fifo, a parameterised sync FIFO with count, push/pop, full/empty. The arbiter FSM, address resolution and output register stay in the top.

Test Plan:
1. Reset released, pipe_wb_valid=1, regdst=01, rd=5'd9, data=32'hA5A5_0001 -> next cycle rf_we=1, rf_waddr=9, rf_wdata=32'hA5A5_0001.
2. regdst=00 rt=3; regdst=10 swi_reg=31; regdst=11 rd=7 on consecutive cycles -> rf_waddr sequence 3, 31, 7, each with rf_we=1.
3. Queue empty, aux push waddr=12 data=32'h1234 with pipe idle -> queued, popped next cycle; rf_we=1, waddr=12 one cycle later; aux_pending returns to 0.
4. Continuous pipe_wb_valid, one aux entry queued -> after 4 cycles of waiting, pipe_stall=1 for exactly one cycle, aux written (waddr from aux), then pipeline writes resume; no pipeline write lost.
5. Push 2 entries while pipe busy -> aux_ready=0. A third aux_valid is not accepted; FIFO order is preserved when drained.
6. Pipeline write to rd=0 -> rf_we stays 0. Assert rst_n low with 2 entries queued -> aux_pending=0, rf_we=0 immediately; no queued writes appear after release.
